// File: rtl/queue_pkg.sv
// queue_pkg: op codes and pointer wrap helper shared by the param_queue slice
package queue_pkg;
    localparam logic [2:0] OP_IDLE   = 3'b000;
    localparam logic [2:0] OP_ENQ    = 3'b001;
    localparam logic [2:0] OP_DEQ    = 3'b010;
    localparam logic [2:0] OP_CLR    = 3'b011;
    localparam logic [2:0] OP_ENQDEQ = 3'b100;
    localparam logic [2:0] OP_PEEK   = 3'b101;

    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/param_queue_if.sv
// param_queue_if: command/data/status bundle between the queue and its producer/consumer
interface param_queue_if #(parameter int WIDTH = 8, parameter int DEPTH = 8);
    logic [2:0]                 op;
    logic [WIDTH-1:0]           in;
    logic [WIDTH-1:0]           out;
    logic                       out_valid;
    logic                       empty;
    logic                       full;
    logic                       almost_full;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       overflow;
    logic                       underflow;

    modport master (output op, in,
                    input out, out_valid, empty, full, almost_full, count, overflow, underflow);
    modport slave  (input op, in,
                    output out, out_valid, empty, full, almost_full, count, overflow, underflow);
endinterface

// File: rtl/queue_mem.sv
// queue_mem: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port
module queue_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/param_queue.sv
// param_queue: parametrised circular-buffer FIFO with peek, occupancy count and sticky error flags
module param_queue
    import queue_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input logic          clk,
    input logic          rst,
    param_queue_if.slave q
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             do_wr, do_rd, adv_rd;

    assign q.empty       = q.count == '0;
    assign q.full        = q.count == CW'(DEPTH);
    assign q.almost_full = q.count >= CW'(AF_LEVEL);

    // ENQDEQ always writes: on a full queue the slot being read is the one overwritten
    assign do_wr  = (q.op == OP_ENQ && !q.full) || q.op == OP_ENQDEQ;
    assign do_rd  = (q.op == OP_DEQ || q.op == OP_ENQDEQ || q.op == OP_PEEK) && !q.empty;
    assign adv_rd = do_rd && q.op != OP_PEEK;

    queue_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_mem (
        .clk   (clk),
        .we    (do_wr && !rst),
        .waddr (wr_ptr),
        .wdata (q.in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            q.count     <= '0;
            q.out       <= '0;
            q.out_valid <= 1'b0;
            q.overflow  <= 1'b0;
            q.underflow <= 1'b0;
        end else if (q.op == OP_CLR) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            q.count     <= '0;
            q.out       <= '0;
            q.out_valid <= 1'b0;
            q.overflow  <= 1'b0;
            q.underflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= PW'(ptr_next(int'(wr_ptr), DEPTH));
            if (adv_rd) rd_ptr <= PW'(ptr_next(int'(rd_ptr), DEPTH));
            if (do_rd) q.out <= rd_data;
            q.out_valid <= do_rd;
            q.count     <= q.count + CW'(do_wr) - CW'(adv_rd);
            q.overflow  <= q.overflow | (q.op == OP_ENQ && q.full);
            q.underflow <= q.underflow | ((q.op == OP_DEQ || q.op == OP_PEEK) && q.empty);
        end
endmodule
